posit_enc_arbiter: RTL

Shares one posit_encoder between NUM_REQ requesters. Arbitration is round-robin. The block latches the winner's unpacked fields (sign, k, exp, mantissa) and drives the encoder's start/received handshake. It returns the 32-bit posit to the winner with a one-cycle ack. It sits between the posit arithmetic units (adder/multiplier normalisers) and the single shared posit_encoder instance.

---
 rtl/posit_enc_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/posit_enc_arbiter.sv
// Round-robin arbiter sharing a single posit_encoder among NUM_REQ requesters.
// Latches the winner's unpacked fields, runs the start/received handshake, and returns the posit with a one-cycle ack.
module posit_enc_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 255,
   localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [NUM_REQ-1:0]    req_sign,
   input  logic [6*NUM_REQ-1:0]  req_k,
   input  logic [3*NUM_REQ-1:0]  req_exp,
   input  logic [32*NUM_REQ-1:0] req_mant,
   output logic [NUM_REQ-1:0]    ack,
   output logic [31:0]           result,
   output logic [IDW-1:0]        result_id,
   output logic                  err,
   output logic                  busy,
   output logic                  enc_start,
   output logic                  enc_received,
   output logic                  enc_sign,
   output logic [5:0]            enc_k,
   output logic [2:0]            enc_exp,
   output logic [31:0]           enc_mant,
   input  logic [31:0]           enc_p_hold,
   input  logic                  enc_done
);

   typedef enum logic [1:0] {IDLE, ISSUE, RELEASE, RESPOND} state_t;

   localparam logic [31:0] NAR = 32'h8000_0000;

   state_t         state;
   logic [IDW-1:0] rr_ptr;
   logic [IDW-1:0] gnt_id;
   logic [IDW-1:0] win_id;
   logic           win_vld;
   logic [15:0]    timer;
   logic           timed_out;

   // Walk offsets from farthest to nearest so the nearest requester above rr_ptr wins.
   always_comb begin
      win_id  = '0;
      win_vld = 1'b0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         if (req[(int'(rr_ptr) + i) % NUM_REQ]) begin
            win_id  = IDW'((int'(rr_ptr) + i) % NUM_REQ);
            win_vld = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         rr_ptr       <= IDW'(NUM_REQ - 1);
         gnt_id       <= '0;
         timer        <= '0;
         timed_out    <= 1'b0;
         ack          <= '0;
         result       <= '0;
         result_id    <= '0;
         err          <= 1'b0;
         busy         <= 1'b0;
         enc_start    <= 1'b0;
         enc_received <= 1'b0;
         enc_sign     <= 1'b0;
         enc_k        <= '0;
         enc_exp      <= '0;
         enc_mant     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (win_vld) begin
                  gnt_id    <= win_id;
                  rr_ptr    <= win_id;
                  enc_sign  <= req_sign[win_id];
                  enc_k     <= req_k[6*int'(win_id) +: 6];
                  enc_exp   <= req_exp[3*int'(win_id) +: 3];
                  enc_mant  <= req_mant[32*int'(win_id) +: 32];
                  enc_start <= 1'b1;
                  busy      <= 1'b1;
                  timer     <= '0;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               if (enc_done) begin
                  result       <= enc_p_hold;
                  timed_out    <= 1'b0;
                  enc_start    <= 1'b0;
                  enc_received <= 1'b1;
                  state        <= RELEASE;
               end else if (timer == 16'(TIMEOUT - 1)) begin
                  result       <= NAR;
                  timed_out    <= 1'b1;
                  enc_start    <= 1'b0;
                  enc_received <= 1'b1;
                  state        <= RELEASE;
               end else begin
                  timer <= timer + 16'd1;
               end
            end
            RELEASE: begin
               // The encoder may hold done for a while after received; wait it out.
               if (!enc_done) begin
                  enc_received <= 1'b0;
                  ack          <= NUM_REQ'(1) << gnt_id;
                  result_id    <= gnt_id;
                  err          <= timed_out;
                  state        <= RESPOND;
               end
            end
            RESPOND: begin
               ack       <= '0;
               result_id <= '0;
               err       <= 1'b0;
               busy      <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
